// File: rtl/lsu_mem_pkg.sv
// Shared types and constants for the LSU-to-memory bridge: size codes,
// bridge FSM states, default address window and size-derived masks.
package lsu_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [63:0] DEF_BASE_ADDR = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DEF_MEM_SIZE  = 64'h0000_0000_0800_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Byte-lane length code presented on the memory write port.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            SZ_B:    mask = 3'b000;
            SZ_H:    mask = 3'b001;
            SZ_W:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extractor: keeps the low 8/16/32/64 bits of the
// memory word and sign- or zero-extends them to 64 bits.
module lsu_load_ext
    import lsu_mem_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [63:0] result
);

    always_comb begin
        result = data;
        case (size)
            SZ_B: result = is_signed ? {{56{data[7]}},  data[7:0]}
                                     : {56'b0,          data[7:0]};
            SZ_H: result = is_signed ? {{48{data[15]}}, data[15:0]}
                                     : {48'b0,          data[15:0]};
            SZ_W: result = is_signed ? {{32{data[31]}}, data[31:0]}
                                     : {32'b0,          data[31:0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Single-outstanding LSU-to-memory bridge: IDLE -> ACCESS -> RESP, with a
// range-checked error path. LSU_MEM_BRIDGE_MISALIGN_CHK_EN also rejects misaligned accesses.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid, once raised, holds its payload stable until that edge.
module lsu_mem_bridge
    import lsu_mem_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [63:0] MEM_SIZE  = DEF_MEM_SIZE
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_write,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd_en,
    output logic [63:0] mem_rd_addr,
    input  logic [63:0] mem_rd_data,
    output logic        mem_we_en,
    output logic [63:0] mem_we_addr,
    output logic [63:0] mem_we_data,
    output logic [7:0]  mem_we_mask,
    output logic [1:0]  dbg_state
);

    state_t      state;
    logic [1:0]  lat_size;
    logic        lat_write;
    logic        lat_signed;
    logic [63:0] ext_data;

    logic [64:0] req_end;
    logic [64:0] win_end;
    logic        range_err;
    logic        req_err;

    // 65-bit arithmetic so an access wrapping past 2^64 compares as out of range.
    assign req_end   = {1'b0, req_addr} + (65'd1 << req_size);
    assign win_end   = {1'b0, BASE_ADDR} + {1'b0, MEM_SIZE};
    assign range_err = (req_addr < BASE_ADDR) || (req_end > win_end);

`ifdef LSU_MEM_BRIDGE_MISALIGN_CHK_EN
    assign req_err = range_err || ((req_addr[2:0] & align_mask(req_size)) != 3'b000);
`else
    assign req_err = range_err;
`endif

    assign req_ready = (state == IDLE) && reset_n;
    assign dbg_state = state;

    lsu_load_ext u_load_ext (
        .data      (mem_rd_data),
        .size      (lat_size),
        .is_signed (lat_signed),
        .result    (ext_data)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            lat_size    <= SZ_B;
            lat_write   <= 1'b0;
            lat_signed  <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 64'b0;
            resp_err    <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= 64'b0;
            mem_we_en   <= 1'b0;
            mem_we_addr <= 64'b0;
            mem_we_data <= 64'b0;
            mem_we_mask <= 8'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_size   <= req_size;
                        lat_write  <= req_write;
                        lat_signed <= req_signed;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 64'b0;
                            state      <= RESP;
                        end else begin
                            state <= ACCESS;
                            if (req_write) begin
                                mem_we_en   <= 1'b1;
                                mem_we_addr <= req_addr;
                                mem_we_data <= req_wdata;
                                mem_we_mask <= size_mask(req_size);
                            end else begin
                                mem_rd_en   <= 1'b1;
                                mem_rd_addr <= req_addr;
                            end
                        end
                    end
                end
                ACCESS: begin
                    mem_rd_en   <= 1'b0;
                    mem_rd_addr <= 64'b0;
                    mem_we_en   <= 1'b0;
                    mem_we_addr <= 64'b0;
                    mem_we_data <= 64'b0;
                    mem_we_mask <= 8'b0;
                    resp_valid  <= 1'b1;
                    resp_err    <= 1'b0;
                    resp_rdata  <= lat_write ? 64'b0 : ext_data;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 64'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed self-checking bench for lsu_mem_bridge; expected values are
// hand-computed per transaction and compared through a single check task.
module tb_lsu_mem_bridge;
    import lsu_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_write;
    logic        req_signed;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd_en;
    logic [63:0] mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic        mem_we_en;
    logic [63:0] mem_we_addr;
    logic [63:0] mem_we_data;
    logic [7:0]  mem_we_mask;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    int          rd_cnt, we_cnt, resp_cyc;
    logic [63:0] rd_addr, we_addr, we_data, rdata;
    logic [7:0]  we_mask;
    logic        err;

    always #5 clock = ~clock;

    lsu_mem_bridge dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_write   (req_write),
        .req_signed  (req_signed),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_we_en   (mem_we_en),
        .mem_we_addr (mem_we_addr),
        .mem_we_data (mem_we_data),
        .mem_we_mask (mem_we_mask),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request, watch the memory port, and retire the response after
    // holding resp_ready low for 'hold' cycles (with an intruding request).
    task automatic run_txn(input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [1:0] size, input logic write,
                           input logic sgn, input int hold);
        logic done;
        rd_cnt = 0; we_cnt = 0; resp_cyc = 0; done = 1'b0;
        rd_addr = '0; we_addr = '0; we_data = '0; we_mask = '0;
        rdata = '0; err = 1'b0;
        @(negedge clock);
        check("req_ready_idle", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1; req_addr = addr; req_wdata = wdata;
        req_size = size; req_write = write; req_signed = sgn;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 16 && !done; k++) begin
            @(negedge clock);
            if (mem_rd_en) begin rd_cnt++; rd_addr = mem_rd_addr; end
            if (mem_we_en) begin
                we_cnt++; we_addr = mem_we_addr; we_data = mem_we_data; we_mask = mem_we_mask;
            end
            if (resp_valid) begin
                if (resp_cyc == 0) begin
                    resp_cyc = k; rdata = resp_rdata; err = resp_err;
                end else begin
                    check("hold_rdata", resp_rdata, rdata);
                    check("hold_req_ready", {63'b0, req_ready}, 64'd0);
                end
                if (k - resp_cyc >= hold) begin
                    resp_ready = 1'b1;
                    @(posedge clock);
                    #1 resp_ready = 1'b0;
                    req_valid = 1'b0;
                    done = 1'b1;
                end else begin
                    req_valid = 1'b1; req_write = 1'b1;
                    req_addr = 64'h8000_0040; req_size = SZ_D;
                end
            end
        end
        if (!done) check("resp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = SZ_B; req_write = 1'b0; req_signed = 1'b0;
        resp_ready = 1'b0; mem_rd_data = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", {63'b0, req_ready}, 64'd0);
        check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_mem_en", {62'b0, mem_rd_en, mem_we_en}, 64'd0);
        check("rst_state", {62'b0, dbg_state}, 64'(IDLE));
        reset_n = 1'b1;
        #1 check("post_rst_req_ready", {63'b0, req_ready}, 64'd1);

        // Signed byte load
        mem_rd_data = 64'h1122_3344_5566_7780;
        run_txn(64'h8000_0003, 64'h0, SZ_B, 1'b0, 1'b1, 0);
        check("lb_rd_cnt", 64'(rd_cnt), 64'd1);
        check("lb_we_cnt", 64'(we_cnt), 64'd0);
        check("lb_rd_addr", rd_addr, 64'h8000_0003);
        check("lb_latency", 64'(resp_cyc), 64'd2);
        check("lb_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_err", {63'b0, err}, 64'd0);

        // Word store
        run_txn(64'h8000_0010, 64'h0000_0000_1234_5678, SZ_W, 1'b1, 1'b0, 0);
        check("sw_we_cnt", 64'(we_cnt), 64'd1);
        check("sw_rd_cnt", 64'(rd_cnt), 64'd0);
        check("sw_we_addr", we_addr, 64'h8000_0010);
        check("sw_we_data", we_data, 64'h0000_0000_1234_5678);
        check("sw_we_mask", {56'b0, we_mask}, 64'h0F);
        check("sw_rdata", rdata, 64'd0);
        check("sw_err", {63'b0, err}, 64'd0);
        check("sw_latency", 64'(resp_cyc), 64'd2);

        // Below the window
        run_txn(64'h7FFF_FFF8, 64'h0, SZ_D, 1'b0, 1'b0, 0);
        check("lo_mem_cnt", 64'(rd_cnt + we_cnt), 64'd0);
        check("lo_latency", 64'(resp_cyc), 64'd1);
        check("lo_err", {63'b0, err}, 64'd1);
        check("lo_rdata", rdata, 64'd0);

        // Misaligned unsigned word
        mem_rd_data = 64'hDEAD_BEEF_8765_4321;
        run_txn(64'h8000_0002, 64'h0, SZ_W, 1'b0, 1'b0, 0);
`ifdef LSU_MEM_BRIDGE_MISALIGN_CHK_EN
        check("mis_err", {63'b0, err}, 64'd1);
        check("mis_rd_cnt", 64'(rd_cnt), 64'd0);
        check("mis_latency", 64'(resp_cyc), 64'd1);
        check("mis_rdata", rdata, 64'd0);
`else
        check("mis_err", {63'b0, err}, 64'd0);
        check("mis_rd_cnt", 64'(rd_cnt), 64'd1);
        check("mis_rd_addr", rd_addr, 64'h8000_0002);
        check("mis_rdata", rdata, 64'h0000_0000_8765_4321);
`endif

        // Response back-pressure with an intruding request
        mem_rd_data = 64'h0000_0000_0000_8001;
        run_txn(64'h8000_0020, 64'h0, SZ_H, 1'b0, 1'b1, 5);
        check("bp_rdata", rdata, 64'hFFFF_FFFF_FFFF_8001);
        check("bp_we_cnt", 64'(we_cnt), 64'd0);
        check("bp_rd_cnt", 64'(rd_cnt), 64'd1);
        @(negedge clock);
        check("bp_after_we_en", {63'b0, mem_we_en}, 64'd0);
        check("bp_after_state", {62'b0, dbg_state}, 64'(IDLE));

        // Boundary: last legal double, first illegal byte, 2^64 wrap
        mem_rd_data = 64'h8123_4567_89AB_CDEF;
        run_txn(64'h87FF_FFF8, 64'h0, SZ_D, 1'b0, 1'b1, 0);
        check("top_err", {63'b0, err}, 64'd0);
        check("top_rdata", rdata, 64'h8123_4567_89AB_CDEF);
        run_txn(64'h8800_0000, 64'h0, SZ_B, 1'b0, 1'b0, 0);
        check("end_err", {63'b0, err}, 64'd1);
        check("end_rd_cnt", 64'(rd_cnt), 64'd0);
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h55, SZ_B, 1'b1, 1'b0, 0);
        check("wrap_err", {63'b0, err}, 64'd1);
        check("wrap_we_cnt", 64'(we_cnt), 64'd0);

        // Reset during ACCESS
        @(negedge clock);
        req_valid = 1'b1; req_addr = 64'h8000_0100; req_size = SZ_D;
        req_write = 1'b0; req_signed = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("ra_access_rd_en", {63'b0, mem_rd_en}, 64'd1);
        reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("ra_mem_en", {62'b0, mem_rd_en, mem_we_en}, 64'd0);
        check("ra_resp_valid", {63'b0, resp_valid}, 64'd0);
        check("ra_state", {62'b0, dbg_state}, 64'(IDLE));
        repeat (3) @(negedge clock);
        check("ra_no_late_resp", {63'b0, resp_valid}, 64'd0);

        mem_rd_data = 64'h0000_0000_0000_00A5;
        run_txn(64'h8000_0008, 64'h0, SZ_B, 1'b0, 1'b0, 0);
        check("ra_next_rdata", rdata, 64'h0000_0000_0000_00A5);
        check("ra_next_err", {63'b0, err}, 64'd0);
        check("ra_next_latency", 64'(resp_cyc), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
